cdc_handshake_tx: RTL and testbench
===================================

Name: cdc_handshake_tx

Overview:
Source-domain sender for a two-phase (toggle) request/acknowledge clock-domain crossing. It accepts a word over a valid/ready interface and holds it stable on data_o. It toggles req_o and waits until the acknowledge toggle returns through an internal multi-flop synchronizer. It pairs with the destination-side receiver, which synchronizes req_o, samples data_o and toggles ack_i back.

Parameters:
WIDTH, 32, payload width in bits (>=1)
SYNC_STAGES, 3, flops in the ack_i synchronizer chain (legal 2..4)
CNT_WIDTH, 16, width of the completed-transfer counter

Ports:
clk  input  1  source-domain clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream offers in_data
in_ready  output  1  block can accept a word (combinational, state==IDLE)
in_data  input  WIDTH  payload from upstream
data_o  output  WIDTH  registered payload to destination domain, stable while busy
req_o  output  1  request toggle to destination domain (registered)
ack_i  input  1  acknowledge toggle from destination domain (asynchronous to clk)
busy_o  output  1  transfer in flight (state==WAIT_ACK)
done_o  output  1  one-cycle pulse on transfer completion
xfer_count_o  output  CNT_WIDTH  completed transfers, wraps modulo 2^CNT_WIDTH
err_o  output  1  sticky protocol error: synchronized ack changed while IDLE

Behaviour:
- Reset (asynchronous assert; deassert is synchronized by the system): state=IDLE, req_o=0, data_o=0, ack sync chain all 0, done_o=0, xfer_count_o=0, err_o=0. in_ready=1 as soon as reset deasserts. The destination resets its ack to 0 as well.
- ack_s is the last flop of the SYNC_STAGES chain. ack_i is sampled only by the first flop, and no logic reads ack_i directly.
- IDLE: in_ready=1, busy_o=0.
  - On a clk edge with in_valid=1: data_o<=in_data, req_o<=~req_o, next state WAIT_ACK.
  - in_data is ignored when in_valid=0.
- WAIT_ACK: in_ready=0, busy_o=1. data_o and req_o are held constant; in_valid and in_data are ignored.
  - On an edge where ack_s==req_o: next state IDLE, done_o<=1, xfer_count_o<=xfer_count_o+1 (wraps to 0 from all-ones).
- Latency: if ack_i toggles before edge k, ack_s matches after edge k+SYNC_STAGES-1. At edge k+SYNC_STAGES, done_o=1 and state=IDLE, so in_ready=1 in that same cycle.
- Back-to-back: in_valid held high with done_o=1 is accepted at the next edge. Minimum spacing between req toggles is therefore SYNC_STAGES+1 clk cycles plus the destination round trip.
- done_o is high for exactly one cycle per completed transfer and is never high in the same cycle as busy_o.
- Error: in IDLE, if ack_s!=req_o on an edge, err_o<=1 and stays high until reset. Normal operation continues.
- Reset mid-transfer: everything returns to reset values immediately. An in-flight word is dropped and no done_o pulse occurs.
- data_o never changes while busy_o=1, which is the CDC guarantee the receiver relies on.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, WAIT_ACK=1'b1) and limits SYNC_STAGES_MIN=2 / SYNC_STAGES_MAX=4, shared with the receiver-side block.
- One natural sub-module: cdc_ack_sync, a 1-bit, SYNC_STAGES-deep flop chain with asynchronous active-high reset to 0. It is kept separate so the CDC-lint waiver applies to one module only.

Test Plan:
- Reset, single word: after reset, in_valid=1 with in_data=0xDEADBEEF for one cycle. Required next cycle: data_o=0xDEADBEEF, req_o=1, busy_o=1, in_ready=0. Then toggle ack_i to 1. Required exactly SYNC_STAGES+1 (4 at default) edges later: done_o=1 for one cycle, xfer_count_o=1, in_ready=1.
- Hold stability: during WAIT_ACK, drive in_valid=1 with a changing in_data every cycle -> data_o and req_o are unchanged and no extra transfer is counted.
- Back-to-back: 5 words 0x1..0x5 with in_valid held high and a destination model echoing req_o to ack_i after 3 cycles -> req_o toggles 5 times, data_o takes each value in order, xfer_count_o=5, 5 done_o pulses.
- Counter wrap: with CNT_WIDTH=4, run 17 transfers -> xfer_count_o reads 0xF after the 15th, 0x0 after the 16th, 0x1 after the 17th.
- Spurious ack: in IDLE with req_o=0, toggle ack_i to 1. Required SYNC_STAGES+1 edges later: err_o=1, held until reset; a following normal transfer still completes.
- Mid-transfer reset: assert reset while busy_o=1 -> outputs go to 0 without waiting for a clock edge. After deassert: in_ready=1, xfer_count_o=0, and no done_o pulse ever appears for the dropped word.

Source files
------------

// File: rtl/cdc_handshake_tx_pkg.sv
// rtl/cdc_handshake_tx_pkg.sv - shared definitions for the toggle-handshake CDC pair
//
// Purpose: state encoding and synchronizer depth limits, shared by the
// source-side sender and the destination-side receiver.
package cdc_handshake_tx_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } hs_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_ack_sync.sv
// rtl/cdc_ack_sync.sv - multi-flop synchronizer for the acknowledge toggle
//
// Purpose: brings the asynchronous ack toggle into the source clock domain.
// This is the only place the asynchronous input is sampled.
// Ports:
//   clk    - source-domain clock
//   reset  - asynchronous active-high reset, clears the chain to 0
//   ack_i  - acknowledge toggle from the destination domain (async)
//   ack_s  - synchronized acknowledge (last flop of the chain)
module cdc_ack_sync
  import cdc_handshake_tx_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ack_i,
  output logic ack_s
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_depth
      $error("cdc_ack_sync: SYNC_STAGES out of range");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift toward the MSB; only bit 0 sees the asynchronous input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source-side sender of a two-phase req/ack clock-domain crossing
//
// Purpose: accepts a word over valid/ready, holds it on data_o, toggles req_o
// and waits for the synchronized ack toggle to match before accepting again.
// Ports:
//   clk, reset    - source clock, asynchronous active-high reset
//   in_valid      - upstream offers in_data
//   in_ready      - word can be accepted (state is IDLE)
//   in_data       - payload from upstream
//   data_o        - registered payload, stable while busy_o is high
//   req_o         - request toggle to the destination domain
//   ack_i         - acknowledge toggle from the destination domain (async)
//   busy_o        - transfer in flight
//   done_o        - one-cycle pulse on transfer completion
//   xfer_count_o  - completed transfers, wraps
//   err_o         - sticky: synchronized ack moved while IDLE
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [WIDTH-1:0]     data_o,
  output logic                 req_o,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] xfer_count_o,
  output logic                 err_o
);

  logic ack_s;

  cdc_ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .ack_i (ack_i),
    .ack_s (ack_s)
  );

  hs_state_e             state_q, state_d;
  logic [WIDTH-1:0]      data_q,  data_d;
  logic                  req_q,   req_d;
  logic                  done_q,  done_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic                  err_q,   err_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // In IDLE the handshake is balanced, so any ack movement is a
        // destination-side protocol violation.
        if (ack_s != req_q) begin
          err_d = 1'b1;
        end
        if (in_valid) begin
          data_d  = in_data;
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Ack toggle has caught up with our request: transfer complete.
        if (ack_s == req_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_WAIT_ACK);
  assign data_o       = data_q;
  assign req_o        = req_q;
  assign done_o       = done_q;
  assign xfer_count_o = cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - directed self-checking bench for cdc_handshake_tx
module tb_cdc_handshake_tx;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 3;
  localparam int CNT_WIDTH   = 4;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [WIDTH-1:0]     data_o;
  logic                 req_o;
  logic                 ack_i;
  logic                 busy_o;
  logic                 done_o;
  logic [CNT_WIDTH-1:0] xfer_count_o;
  logic                 err_o;

  logic       man_ack;
  logic       echo_en;
  logic [2:0] req_hist;

  int checks;
  int errors;

  cdc_handshake_tx #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .data_o       (data_o),
    .req_o        (req_o),
    .ack_i        (ack_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .xfer_count_o (xfer_count_o),
    .err_o        (err_o)
  );

  // Destination model: either manual ack, or req_o echoed three cycles late.
  assign ack_i = echo_en ? req_hist[2] : man_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    req_hist = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      req_hist = {req_hist[1:0], req_o};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer with a manually driven ack; returns once done_o is seen.
  task automatic xfer(input logic [WIDTH-1:0] d);
    logic got;
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    man_ack  = req_o;
    got      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    check("xfer_done", 64'(got), 64'd1);
  endtask

  initial begin
    int sent;
    int dones;
    int toggles;
    int cyc;
    logic prev_req;
    logic will_accept;

    checks   = 0;
    errors   = 0;
    echo_en  = 1'b0;
    man_ack  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;

    // Reset state
    step();
    step();
    check("rst_req",   64'(req_o), 64'd0);
    check("rst_data",  64'(data_o), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_done",  64'(done_o), 64'd0);
    check("rst_count", 64'(xfer_count_o), 64'd0);
    check("rst_err",   64'(err_o), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(in_ready), 64'd1);

    // Single word and ack latency
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    check("single_data",  64'(data_o), 64'hDEADBEEF);
    check("single_req",   64'(req_o), 64'd1);
    check("single_busy",  64'(busy_o), 64'd1);
    check("single_ready", 64'(in_ready), 64'd0);
    man_ack = 1'b1;
    step();
    step();
    step();
    check("lat_no_early_done", 64'(done_o), 64'd0);
    check("lat_still_busy",    64'(busy_o), 64'd1);
    step();
    check("lat_done",  64'(done_o), 64'd1);
    check("lat_count", 64'(xfer_count_o), 64'd1);
    check("lat_ready", 64'(in_ready), 64'd1);
    check("lat_busy",  64'(busy_o), 64'd0);
    step();
    check("lat_done_one_cycle", 64'(done_o), 64'd0);

    // Hold stability while waiting for ack
    in_valid = 1'b1;
    in_data  = 32'h11111111;
    step();
    for (int i = 0; i < 6; i++) begin
      in_data = $urandom;
      step();
      check("hold_data",  64'(data_o), 64'h11111111);
      check("hold_req",   64'(req_o), 64'd0);
      check("hold_count", 64'(xfer_count_o), 64'd1);
    end
    in_valid = 1'b0;
    man_ack  = 1'b0;
    dones    = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o) dones++;
    end
    check("hold_dones", 64'(dones), 64'd1);
    check("hold_count_after", 64'(xfer_count_o), 64'd2);

    // Back-to-back with the echoing destination
    echo_en  = 1'b1;
    sent     = 0;
    dones    = 0;
    toggles  = 0;
    prev_req = req_o;
    in_valid = 1'b1;
    in_data  = 32'd1;
    cyc      = 0;
    while (dones < 5 && cyc < 200) begin
      will_accept = in_ready && in_valid;
      step();
      cyc++;
      if (req_o != prev_req) toggles++;
      prev_req = req_o;
      if (will_accept) begin
        sent++;
        check("b2b_data", 64'(data_o), 64'(sent));
        in_data = WIDTH'(sent + 1);
        if (sent == 5) in_valid = 1'b0;
      end
      if (done_o) dones++;
      if (done_o && busy_o) check("done_with_busy", 64'd1, 64'd0);
    end
    check("b2b_dones",   64'(dones), 64'd5);
    check("b2b_toggles", 64'(toggles), 64'd5);
    check("b2b_count",   64'(xfer_count_o), 64'd7);
    check("b2b_req",     64'(req_o), 64'd1);
    man_ack = 1'b1;
    step();
    echo_en = 1'b0;
    step();

    // Reset in the middle of a transfer
    in_valid = 1'b1;
    in_data  = 32'hCAFEF00D;
    step();
    in_valid = 1'b0;
    check("mid_busy_before", 64'(busy_o), 64'd1);
    #2;
    reset   = 1'b1;
    man_ack = 1'b0;
    #1;
    check("mid_req",   64'(req_o), 64'd0);
    check("mid_data",  64'(data_o), 64'd0);
    check("mid_busy",  64'(busy_o), 64'd0);
    check("mid_count", 64'(xfer_count_o), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("mid_ready", 64'(in_ready), 64'd1);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o) dones++;
    end
    check("mid_no_done", 64'(dones), 64'd0);
    check("mid_count_after", 64'(xfer_count_o), 64'd0);
    check("mid_err", 64'(err_o), 64'd0);

    // Counter wrap at CNT_WIDTH=4
    for (int i = 1; i <= 17; i++) begin
      xfer(WIDTH'(i));
      if (i == 15) check("wrap_15", 64'(xfer_count_o), 64'hF);
      if (i == 16) check("wrap_16", 64'(xfer_count_o), 64'h0);
      if (i == 17) check("wrap_17", 64'(xfer_count_o), 64'h1);
    end

    // Spurious ack in IDLE
    xfer(32'hA5A5A5A5);
    check("spur_req0", 64'(req_o), 64'd0);
    step();
    man_ack = 1'b1;
    step();
    step();
    step();
    check("spur_err_early", 64'(err_o), 64'd0);
    step();
    check("spur_err", 64'(err_o), 64'd1);
    step();
    step();
    check("spur_err_sticky", 64'(err_o), 64'd1);
    xfer(32'h5A5A5A5A);
    check("spur_count", 64'(xfer_count_o), 64'd3);
    check("spur_data",  64'(data_o), 64'h5A5A5A5A);
    check("spur_err_hold", 64'(err_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
